multiplier_controller_taint_track_1bit: RTL and testbench

MULTIPLIER_CONTROLLER_TAINT_TRACK_1BIT -- requirements
Module: multiplier_controller_taint_track_1bit

---
 rtl/multiplier_controller_taint_track_1bit.sv | 116 +++++++++++
 tb/tb_multiplier_controller_taint_track_1bit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_controller_taint_track_1bit.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_controller_taint_track_1bit
// Description : Shift-and-add multiplier sequencer with sticky 1-bit taint
//               propagation onto every datapath control.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_controller_taint_track_1bit #(
    parameter int WIDTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     start_t,
    input  logic [WIDTH-1:0]         multiplierReg,
    input  logic                     multiplierReg_t,
    output logic                     mrld,
    output logic                     mdld,
    output logic                     rsclear,
    output logic                     rsload,
    output logic                     rsshr,
    output logic                     mrld_t,
    output logic                     mdld_t,
    output logic                     rsclear_t,
    output logic                     rsload_t,
    output logic                     rsshr_t,
    output logic                     busy,
    output logic                     done,
    output logic                     done_t,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] c_one      = IDXW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_bit_idx;
    logic            r_fsm_t;

    // Taint only accumulates while idle, so a tainted request marks the whole
    // operation it launches and every later one until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_idx <= '0;
            r_fsm_t   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fsm_t <= r_fsm_t | start_t;
                    if (start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_bit_idx <= '0;
                    r_state   <= ST_CALC;
                end
                ST_CALC: begin
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_bit_idx == c_last_idx) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_bit_idx <= r_bit_idx + c_one;
                        r_state   <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    logic w_in_load;
    logic w_in_calc;

    always_comb begin
        w_in_load = (r_state == ST_LOAD);
        w_in_calc = (r_state == ST_CALC);
    end

    // rsload is the only control that looks at data: the current multiplier bit.
    always_comb begin
        mrld      = w_in_load;
        mdld      = w_in_load;
        rsclear   = w_in_load;
        rsload    = w_in_calc & multiplierReg[r_bit_idx];
        rsshr     = (r_state == ST_SHIFT);
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        mrld_t    = r_fsm_t;
        mdld_t    = r_fsm_t;
        rsclear_t = r_fsm_t;
        rsload_t  = r_fsm_t | (w_in_calc & multiplierReg_t);
        rsshr_t   = r_fsm_t;
        done_t    = r_fsm_t;
        bit_idx   = r_bit_idx;
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_controller_taint_track_1bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_controller_taint_track_1bit
// Description : Randomized bench for the multiplier controller, WIDTH 4 and 8,
//               against a cycle-count reference model and a shift-add datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_controller_taint_track_1bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_t = 1'b0;
    logic       mreg_t = 1'b0;
    logic [3:0] mreg4 = '0;
    logic [7:0] mreg8 = '0;

    logic mrld4, mdld4, rsclear4, rsload4, rsshr4, busy4, done4;
    logic mrld_t4, mdld_t4, rsclear_t4, rsload_t4, rsshr_t4, done_t4;
    logic [1:0] bi4;
    logic mrld8, mdld8, rsclear8, rsload8, rsshr8, busy8, done8;
    logic mrld_t8, mdld_t8, rsclear_t8, rsload_t8, rsshr_t8, done_t8;
    logic [2:0] bi8;

    always #5 clk = ~clk;

    multiplier_controller_taint_track_1bit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
        .multiplierReg(mreg4), .multiplierReg_t(mreg_t),
        .mrld(mrld4), .mdld(mdld4), .rsclear(rsclear4), .rsload(rsload4), .rsshr(rsshr4),
        .mrld_t(mrld_t4), .mdld_t(mdld_t4), .rsclear_t(rsclear_t4), .rsload_t(rsload_t4),
        .rsshr_t(rsshr_t4), .busy(busy4), .done(done4), .done_t(done_t4), .bit_idx(bi4)
    );

    multiplier_controller_taint_track_1bit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
        .multiplierReg(mreg8), .multiplierReg_t(mreg_t),
        .mrld(mrld8), .mdld(mdld8), .rsclear(rsclear8), .rsload(rsload8), .rsshr(rsshr8),
        .mrld_t(mrld_t8), .mdld_t(mdld_t8), .rsclear_t(rsclear_t8), .rsload_t(rsload_t8),
        .rsshr_t(rsshr_t8), .busy(busy8), .done(done8), .done_t(done_t8), .bit_idx(bi8)
    );

    logic [12:0] obs4, obs8;
    assign obs4 = {busy4, done4, mrld4, mdld4, rsclear4, rsload4, rsshr4,
                   done_t4, mrld_t4, mdld_t4, rsclear_t4, rsload_t4, rsshr_t4};
    assign obs8 = {busy8, done8, mrld8, mdld8, rsclear8, rsload8, rsshr8,
                   done_t8, mrld_t8, mdld_t8, rsclear_t8, rsload_t8, rsshr_t8};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: cycles elapsed since acceptance (0 = idle) and sticky taint.
    int         cnt4 = 0, cnt8 = 0;
    logic       tnt4 = 1'b0, tnt8 = 1'b0;
    longint     rs4 = 0, rs8 = 0;
    logic [3:0] md4 = '0;
    logic [7:0] md8 = '0;
    int         cyc = 0;
    int         last4 = -1, last8 = -1;
    bit         chk_period = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // An operation is 1 LOAD cycle, W CALC/SHIFT pairs, then 1 DONE cycle.
    function automatic logic [12:0] exp_vec(int cnt, int w, logic [7:0] mreg, logic t, logic mt);
        logic ld, dn, calc, shift;
        int   idx;
        ld    = (cnt == 1);
        dn    = (cnt == 2 * w + 2);
        calc  = (cnt >= 2) && (cnt <= 2 * w + 1) && (cnt % 2 == 0);
        shift = (cnt >= 3) && (cnt <= 2 * w + 1) && (cnt % 2 == 1);
        idx   = calc ? (cnt - 2) / 2 : 0;
        return {cnt != 0, dn, ld, ld, ld, calc & mreg[idx], shift,
                t, t, t, t, t | (calc & mt), t};
    endfunction

    function automatic int exp_idx(int cnt, int w);
        if (cnt == 2 * w + 2) return w - 1;
        if (cnt >= 2 && cnt <= 2 * w + 1) return (cnt - 2) / 2;
        return -1;
    endfunction

    task automatic step(input int cin, input logic tin, input int w,
                        output int cout, output logic tout);
        tout = tin;
        if (cin == 0) begin
            tout = tin | start_t;
            cout = start ? 1 : 0;
        end else if (cin == 2 * w + 2) begin
            cout = 0;
        end else begin
            cout = cin + 1;
        end
    endtask

    task automatic compare();
        int i;
        check("ctl4", obs4, exp_vec(cnt4, 4, {4'b0, mreg4}, tnt4, mreg_t));
        check("ctl8", obs8, exp_vec(cnt8, 8, mreg8, tnt8, mreg_t));
        i = exp_idx(cnt4, 4);
        if (i >= 0) check("idx4", 64'(bi4), 64'(i));
        i = exp_idx(cnt8, 8);
        if (i >= 0) check("idx8", 64'(bi8), 64'(i));
        if (cnt4 == 10) begin
            check("prod4", rs4, 64'(md4) * 64'(mreg4));
            if (chk_period && last4 >= 0) check("period4", 64'(cyc - last4), 64'd11);
            last4 = cyc;
        end
        if (cnt8 == 18) begin
            check("prod8", rs8, 64'(md8) * 64'(mreg8));
            if (chk_period && last8 >= 0) check("period8", 64'(cyc - last8), 64'd19);
            last8 = cyc;
        end
        // Behavioural running-sum datapath driven by the controls of this cycle.
        if (rsclear4) rs4 = 0;
        if (rsload4)  rs4 = rs4 + (longint'(md4) << 4);
        if (rsshr4)   rs4 = rs4 >> 1;
        if (rsclear8) rs8 = 0;
        if (rsload8)  rs8 = rs8 + (longint'(md8) << 8);
        if (rsshr8)   rs8 = rs8 >> 1;
    endtask

    task automatic tick();
        int   c;
        logic t;
        @(posedge clk);
        if (rst_n) begin
            step(cnt4, tnt4, 4, c, t); cnt4 = c; tnt4 = t;
            step(cnt8, tnt8, 8, c, t); cnt8 = c; tnt8 = t;
        end
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "4"}, obs4, 13'd0);
        check({tag, "8"}, obs8, 13'd0);
        check({tag, "_idx4"}, 64'(bi4), 64'd0);
        check({tag, "_idx8"}, 64'(bi8), 64'd0);
    endtask

    // Called at a falling edge: asserts reset mid-cycle and checks the async clear.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");
        cnt4 = 0; cnt8 = 0; tnt4 = 1'b0; tnt8 = 1'b0; last4 = -1; last8 = -1;
        @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        #1 check_zero("rst_rel");
    endtask

    task automatic run_until_idle(input int n);
        for (int i = 0; i < n && !(cnt4 == 0 && cnt8 == 0); i++) tick();
        check("idle_timeout", 64'(cnt4 + cnt8), 64'd0);
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset held from time zero, then released.
        @(negedge clk);
        check_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_zero("rst_init_rel");

        // Basic multiply: 13 * 4'b1011 = 143.
        mreg4 = 4'b1011; md4 = 4'd13; mreg8 = 8'hA5; md8 = 8'd200;
        launch();
        run_until_idle(30);
        check("basic_prod143", rs4, 64'd143);

        // Zero multiplier.
        mreg4 = '0; mreg8 = '0; md4 = 4'(unsigned'($urandom)); md8 = 8'(unsigned'($urandom));
        launch();
        run_until_idle(30);

        // Start pulsed during CALC and during DONE is ignored.
        mreg4 = 4'(unsigned'($urandom)); mreg8 = 8'(unsigned'($urandom));
        launch();
        for (int i = 0; i < 30 && !(cnt4 == 0 && cnt8 == 0); i++) begin
            start = (cnt4 == 2) || (cnt4 == 10);
            tick();
        end
        start = 1'b0;
        run_until_idle(30);

        // Taint: data taint alone, then a tainted start that sticks.
        mreg_t = 1'b1; start_t = 1'b0;
        launch();
        run_until_idle(30);
        start_t = 1'b1;
        launch();
        start_t = 1'b0; mreg_t = 1'b0;
        run_until_idle(30);
        launch();
        run_until_idle(30);

        // Reset during the third CALC cycle, then a full run.
        mreg4 = 4'hF; mreg8 = 8'hFF;
        launch();
        for (int i = 0; i < 10 && cnt4 != 6; i++) tick();
        check("reach_calc3", 64'(cnt4), 64'd6);
        mid_reset();
        launch();
        run_until_idle(30);

        // Start held high: back-to-back operations.
        chk_period = 1'b1; last4 = -1; last8 = -1;
        start = 1'b1;
        repeat (60) tick();
        start = 1'b0;
        chk_period = 1'b0;
        run_until_idle(30);

        // Randomized traffic with occasional asynchronous resets.
        repeat (500) begin
            if (cnt4 == 0) begin
                mreg4 = 4'(unsigned'($urandom)); md4 = 4'(unsigned'($urandom));
            end
            if (cnt8 == 0) begin
                mreg8 = 8'(unsigned'($urandom)); md8 = 8'(unsigned'($urandom));
            end
            start   = ($urandom_range(0, 3) == 0);
            start_t = ($urandom_range(0, 15) == 0);
            mreg_t  = 1'($urandom);
            if ($urandom_range(0, 99) == 0) mid_reset();
            else tick();
        end
        start = 1'b0; start_t = 1'b0;
        run_until_idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
